// File: rtl/ex_stage_pkg.sv
// Shared widths, stall encodings, opcode/funct constants and divider states for the EX stage.
package ex_stage_pkg;
  localparam int DATA_W       = 32;
  localparam int ID_TO_EX_WD  = 223;
  localparam int EX_TO_MEM_WD = 76;
  localparam int EX_TO_ID_WD  = 38;
  localparam int StallBus     = 6;
  localparam int DIV_CNT_W    = 5;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // One-hot alu_op bit positions, MSB first: add sub slt sltu and nor or xor sll srl sra lui
  localparam int ALU_ADD  = 11;
  localparam int ALU_SUB  = 10;
  localparam int ALU_SLT  = 9;
  localparam int ALU_SLTU = 8;
  localparam int ALU_AND  = 7;
  localparam int ALU_NOR  = 6;
  localparam int ALU_OR   = 5;
  localparam int ALU_XOR  = 4;
  localparam int ALU_SLL  = 3;
  localparam int ALU_SRL  = 2;
  localparam int ALU_SRA  = 1;
  localparam int ALU_LUI  = 0;

  localparam logic [5:0] OPC_SPECIAL = 6'h00;
  localparam logic [5:0] OPC_LB      = 6'h20;
  localparam logic [5:0] OPC_LW      = 6'h23;
  localparam logic [5:0] OPC_LBU     = 6'h24;
  localparam logic [5:0] FN_MFHI     = 6'h10;
  localparam logic [5:0] FN_MTHI     = 6'h11;
  localparam logic [5:0] FN_MFLO     = 6'h12;
  localparam logic [5:0] FN_MTLO     = 6'h13;
  localparam logic [5:0] FN_MULT     = 6'h18;
  localparam logic [5:0] FN_MULTU    = 6'h19;
  localparam logic [5:0] FN_DIV      = 6'h1A;
  localparam logic [5:0] FN_DIVU     = 6'h1B;

  function automatic logic [DATA_W-1:0] neg_if(input logic neg, input logic [DATA_W-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction
endpackage

// File: rtl/div_iter.sv
// Radix-2 restoring divider: one quotient bit per cycle over 32 BUSY cycles, result shown in DONE.
module div_iter import ex_stage_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quot,
  output logic [DATA_W-1:0] rem
);
  div_state_e           state, state_nxt;
  logic [DIV_CNT_W-1:0] cnt;
  logic [DATA_W-1:0]    q_r, r_r, d_r;
  logic                 neg_q, neg_r, b_zero;
  logic                 a_neg, b_neg;
  logic [DATA_W:0]      r_sh, diff;

  assign a_neg = signed_en & a[DATA_W-1];
  assign b_neg = signed_en & b[DATA_W-1];
  // diff[DATA_W] set means the trial subtraction went negative: restore
  assign r_sh  = {r_r, q_r[DATA_W-1]};
  assign diff  = r_sh - {1'b0, d_r};

  always_comb begin
    state_nxt = state;
    case (state)
      DIV_IDLE: if (start) state_nxt = DIV_BUSY;
      DIV_BUSY: if (cnt == 5'd31) state_nxt = DIV_DONE;
      DIV_DONE: state_nxt = DIV_IDLE;
      default:  state_nxt = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= DIV_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0; q_r <= '0; r_r <= '0; d_r <= '0;
      neg_q <= 1'b0; neg_r <= 1'b0; b_zero <= 1'b0;
    end else if (state == DIV_IDLE && start) begin
      cnt    <= '0;
      q_r    <= neg_if(a_neg, a);
      d_r    <= neg_if(b_neg, b);
      r_r    <= '0;
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      b_zero <= (b == '0);
    end else if (state == DIV_BUSY) begin
      cnt <= cnt + 1'b1;
      if (!diff[DATA_W]) begin
        r_r <= diff[DATA_W-1:0];
        q_r <= {q_r[DATA_W-2:0], 1'b1};
      end else begin
        r_r <= r_sh[DATA_W-1:0];
        q_r <= {q_r[DATA_W-2:0], 1'b0};
      end
    end
  end

  // Divide by zero: remainder magnitude is |a|, so re-applying the sign returns the dividend
  assign busy = (state == DIV_BUSY);
  assign done = (state == DIV_DONE);
  assign quot = b_zero ? '1 : neg_if(neg_q, q_r);
  assign rem  = neg_if(neg_r, r_r);
endmodule

// File: rtl/ex_stage.sv
// Execute stage: ID/EX pipeline register, ALU, mult, HI/LO moves, memory request and iterative divide.
module ex_stage import ex_stage_pkg::*; (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [StallBus-1:0]     stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [EX_TO_ID_WD-1:0]  ex_to_id_bus,
  output logic [64:0]             ex_hilo,
  output logic                    inst_is_load,
  output logic                    stallreq_for_div,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [DATA_W-1:0]       data_sram_addr,
  output logic [DATA_W-1:0]       data_sram_wdata
);
  logic [ID_TO_EX_WD-1:0] id_to_ex_p0;

  // ID -> EX boundary: bubble when ID stops but EX runs, hold when both stop
  always_ff @(posedge clk) begin
    if (rst)                                     id_to_ex_p0 <= '0;
    else if (stall[2] == Stop && stall[3] == NoStop) id_to_ex_p0 <= '0;
    else if (stall[2] == NoStop)                 id_to_ex_p0 <= id_to_ex_bus;
  end

  logic [DATA_W-1:0] hi_data, lo_data, pc, inst, rdata1, rdata2;
  logic [11:0]       alu_op;
  logic [2:0]        sel_alu_src1;
  logic [3:0]        sel_alu_src2;
  logic [3:0]        data_ram_wen;
  logic [4:0]        rf_waddr;
  logic              data_ram_en, rf_we, sel_rf_res;

  assign {hi_data, lo_data, pc, inst, alu_op, sel_alu_src1, sel_alu_src2, data_ram_en,
          data_ram_wen, rf_we, rf_waddr, sel_rf_res, rdata1, rdata2} = id_to_ex_p0;

  logic [5:0] opcode, funct;
  logic       special, is_mfhi, is_mflo, is_mthi, is_mtlo, is_mult, is_multu, is_div;
  assign opcode   = inst[31:26];
  assign funct    = inst[5:0];
  assign special  = (opcode == OPC_SPECIAL);
  assign is_mfhi  = special && funct == FN_MFHI;
  assign is_mflo  = special && funct == FN_MFLO;
  assign is_mthi  = special && funct == FN_MTHI;
  assign is_mtlo  = special && funct == FN_MTLO;
  assign is_mult  = special && funct == FN_MULT;
  assign is_multu = special && funct == FN_MULTU;
  assign is_div   = special && (funct == FN_DIV || funct == FN_DIVU);
  assign inst_is_load = (opcode == OPC_LW) || (opcode == OPC_LB) || (opcode == OPC_LBU);

  logic [DATA_W-1:0]        src1, src2, alu_res, ex_result;
  logic signed [DATA_W-1:0] src1_s, src2_s;
  assign src1 = ({DATA_W{sel_alu_src1[0]}} & rdata1)
              | ({DATA_W{sel_alu_src1[1]}} & pc)
              | ({DATA_W{sel_alu_src1[2]}} & {27'd0, inst[10:6]});
  assign src2 = ({DATA_W{sel_alu_src2[0]}} & rdata2)
              | ({DATA_W{sel_alu_src2[1]}} & {{16{inst[15]}}, inst[15:0]})
              | ({DATA_W{sel_alu_src2[2]}} & 32'd8)
              | ({DATA_W{sel_alu_src2[3]}} & {16'd0, inst[15:0]});
  assign src1_s = src1;
  assign src2_s = src2;

  always_comb begin
    alu_res = '0;
    case (1'b1)
      alu_op[ALU_ADD]:  alu_res = src1 + src2;
      alu_op[ALU_SUB]:  alu_res = src1 - src2;
      alu_op[ALU_SLT]:  alu_res = {31'd0, src1_s < src2_s};
      alu_op[ALU_SLTU]: alu_res = {31'd0, src1 < src2};
      alu_op[ALU_AND]:  alu_res = src1 & src2;
      alu_op[ALU_NOR]:  alu_res = ~(src1 | src2);
      alu_op[ALU_OR]:   alu_res = src1 | src2;
      alu_op[ALU_XOR]:  alu_res = src1 ^ src2;
      alu_op[ALU_SLL]:  alu_res = src2 << src1[4:0];
      alu_op[ALU_SRL]:  alu_res = src2 >> src1[4:0];
      alu_op[ALU_SRA]:  alu_res = $unsigned(src2_s >>> src1[4:0]);
      alu_op[ALU_LUI]:  alu_res = {src2[15:0], 16'd0};
      default:          alu_res = '0;
    endcase
  end

  assign ex_result = is_mfhi ? hi_data : (is_mflo ? lo_data : alu_res);

  logic [63:0] prod_s, prod_u;
  assign prod_s = {{32{rdata1[31]}}, rdata1} * {{32{rdata2[31]}}, rdata2};
  assign prod_u = {32'd0, rdata1} * {32'd0, rdata2};

  logic              div_start, div_busy, div_done;
  logic [DATA_W-1:0] div_quot, div_rem;
  assign div_start = is_div && !div_busy && !div_done;

  div_iter u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .signed_en (funct == FN_DIV),
    .a         (rdata1),
    .b         (rdata2),
    .busy      (div_busy),
    .done      (div_done),
    .quot      (div_quot),
    .rem       (div_rem)
  );

  assign stallreq_for_div = div_start | div_busy;

  logic              hilo_we;
  logic [DATA_W-1:0] hi_wdata, lo_wdata;
  always_comb begin
    hilo_we  = 1'b0;
    hi_wdata = hi_data;
    lo_wdata = lo_data;
    if (div_done) begin
      hilo_we = 1'b1; hi_wdata = div_rem; lo_wdata = div_quot;
    end else if (is_mult) begin
      hilo_we = 1'b1; {hi_wdata, lo_wdata} = prod_s;
    end else if (is_multu) begin
      hilo_we = 1'b1; {hi_wdata, lo_wdata} = prod_u;
    end else if (is_mthi) begin
      hilo_we = 1'b1; hi_wdata = rdata1;
    end else if (is_mtlo) begin
      hilo_we = 1'b1; lo_wdata = rdata1;
    end
  end
  assign ex_hilo = {hilo_we, hi_wdata, lo_wdata};

  // A held instruction must not write the register file or memory while the divider runs
  logic       rf_we_ex, ram_en_ex;
  logic [3:0] ram_wen_ex;
  assign rf_we_ex   = rf_we & ~stallreq_for_div;
  assign ram_en_ex  = data_ram_en & ~stallreq_for_div;
  assign ram_wen_ex = data_ram_wen & {4{~stallreq_for_div}};

  assign data_sram_en    = ram_en_ex;
  assign data_sram_wen   = ram_wen_ex;
  assign data_sram_addr  = alu_res;
  assign data_sram_wdata = rdata2;

  assign ex_to_mem_bus = {pc, ram_en_ex, ram_wen_ex, sel_rf_res, rf_we_ex, rf_waddr, ex_result};
  assign ex_to_id_bus  = {rf_we_ex, rf_waddr, ex_result};

  logic unused_bits;
  assign unused_bits = ^{stall[5:4], stall[1:0], inst[25:16]};
endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed vector table, hand sequences for divide/stall/reset, randomized model checks.
module tb_ex_stage;
  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   stall, stall_drv;
  logic [222:0] id_to_ex_bus;
  logic [75:0]  ex_to_mem_bus;
  logic [37:0]  ex_to_id_bus;
  logic [64:0]  ex_hilo;
  logic         inst_is_load, stallreq_for_div, data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr, data_sram_wdata;

  ex_stage dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .id_to_ex_bus     (id_to_ex_bus),
    .ex_to_mem_bus    (ex_to_mem_bus),
    .ex_to_id_bus     (ex_to_id_bus),
    .ex_hilo          (ex_hilo),
    .inst_is_load     (inst_is_load),
    .stallreq_for_div (stallreq_for_div),
    .data_sram_en     (data_sram_en),
    .data_sram_wen    (data_sram_wen),
    .data_sram_addr   (data_sram_addr),
    .data_sram_wdata  (data_sram_wdata)
  );

  always #5 clk = ~clk;

  // Minimal pipeline controller: a divide request freezes IF/ID/EX
  assign stall = stallreq_for_div ? 6'b001111 : stall_drv;

  localparam logic [11:0] OP_ADD = 12'h800, OP_SUB = 12'h400, OP_SLT = 12'h200, OP_SLTU = 12'h100,
                          OP_AND = 12'h080, OP_NOR = 12'h040, OP_OR  = 12'h020, OP_XOR  = 12'h010,
                          OP_SLL = 12'h008, OP_SRL = 12'h004, OP_SRA = 12'h002, OP_LUI  = 12'h001;
  localparam logic [31:0] PC0 = 32'hBFC0_0000, HI0 = 32'hDEAD_0001, LO0 = 32'hBEEF_0002;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] r_inst(input logic [4:0] rs, rt, rd, sa, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sa, fn};
  endfunction

  function automatic logic [31:0] i_inst(input logic [5:0] opc, input logic [4:0] rs, rt,
                                         input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  function automatic logic [222:0] mk(input logic [31:0] inst, input logic [11:0] op,
                                      input logic [2:0] s1, input logic [3:0] s2,
                                      input logic ram_en, input logic [3:0] wen,
                                      input logic rf_we, input logic [4:0] waddr,
                                      input logic sel_rf_res, input logic [31:0] r1, r2);
    return {HI0, LO0, PC0, inst, op, s1, s2, ram_en, wen, rf_we, waddr, sel_rf_res, r1, r2};
  endfunction

  // Reference ALU from the operation definitions; k indexes add..lui in that order
  function automatic logic [31:0] alu_model(input int k, input logic [31:0] a, b);
    logic signed [31:0] as, bs;
    as = a; bs = b;
    case (k)
      0:  return a + b;
      1:  return a - b;
      2:  return (as < bs) ? 32'd1 : 32'd0;
      3:  return (a < b) ? 32'd1 : 32'd0;
      4:  return a & b;
      5:  return ~(a | b);
      6:  return a | b;
      7:  return a ^ b;
      8:  return b << a[4:0];
      9:  return b >> a[4:0];
      10: return bs >>> a[4:0];
      default: return {b[15:0], 16'h0000};
    endcase
  endfunction

  // Returns {remainder, quotient}
  function automatic logic [63:0] div_model(input logic sgn, input logic [31:0] a, b);
    longint sa, sb, q, r;
    logic [31:0] uq, ur;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = longint'($signed(a)); sb = longint'($signed(b));
      q = sa / sb; r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    uq = a / b; ur = a % b;
    return {ur, uq};
  endfunction

  task automatic issue(input logic [222:0] bus);
    id_to_ex_bus = bus;
    stall_drv = 6'd0;
    @(posedge clk); #1;
  endtask

  task automatic run_div(input string name, input logic sgn, input logic [31:0] a, b,
                         input logic [31:0] exp_q, exp_r);
    int cyc;
    id_to_ex_bus = mk(r_inst(5'd1, 5'd2, 5'd0, 5'd0, sgn ? 6'h1A : 6'h1B), 12'd0, 3'd0, 4'd0,
                      1'b1, 4'hF, 1'b1, 5'd7, 1'b0, a, b);
    stall_drv = 6'd0;
    @(posedge clk); #1;
    cyc = 0;
    while (stallreq_for_div === 1'b1 && cyc < 100) begin
      if (cyc == 5)
        chk({name, " suppress"}, 80'({ex_to_mem_bus[37], data_sram_en, data_sram_wen}), 80'd0);
      cyc++;
      @(posedge clk); #1;
    end
    chk({name, " stall cycles"}, 80'(cyc), 80'd33);
    chk({name, " hilo"}, 80'(ex_hilo), 80'({1'b1, exp_r, exp_q}));
    id_to_ex_bus = '0;
    @(posedge clk); #1;
    chk({name, " back idle"}, 80'({stallreq_for_div, ex_hilo[64]}), 80'd0);
  endtask

  typedef struct {
    string       name;
    logic [11:0] op;
    logic [2:0]  s1;
    logic [3:0]  s2;
    logic [31:0] inst, r1, r2, exp;
  } vec_t;

  function automatic vec_t v(input string nm, input logic [11:0] op, input logic [2:0] s1,
                             input logic [3:0] s2, input logic [31:0] inst, r1, r2, exp);
    vec_t t;
    t.name = nm; t.op = op; t.s1 = s1; t.s2 = s2; t.inst = inst; t.r1 = r1; t.r2 = r2; t.exp = exp;
    return t;
  endfunction

  vec_t tbl[$];

  initial begin
    logic [31:0] r1, r2, expv;
    logic [15:0] imm;
    logic [11:0] op;
    logic [3:0]  s2;
    logic [63:0] m;
    logic        sgn;
    int          k, sel;

    tbl.push_back(v("addu",  OP_ADD,  3'b001, 4'b0001, r_inst(1, 2, 9, 0, 6'h21), 32'd5, 32'd7, 32'd12));
    tbl.push_back(v("subu",  OP_SUB,  3'b001, 4'b0001, r_inst(1, 2, 9, 0, 6'h23), 32'd3, 32'd10, 32'hFFFF_FFF9));
    tbl.push_back(v("slt",   OP_SLT,  3'b001, 4'b0001, r_inst(1, 2, 9, 0, 6'h2A), 32'hFFFF_FFFF, 32'd1, 32'd1));
    tbl.push_back(v("sltu",  OP_SLTU, 3'b001, 4'b0001, r_inst(1, 2, 9, 0, 6'h2B), 32'hFFFF_FFFF, 32'd1, 32'd0));
    tbl.push_back(v("and",   OP_AND,  3'b001, 4'b0001, r_inst(1, 2, 9, 0, 6'h24), 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0));
    tbl.push_back(v("nor",   OP_NOR,  3'b001, 4'b0001, r_inst(1, 2, 9, 0, 6'h27), 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h000F_000F));
    tbl.push_back(v("or",    OP_OR,   3'b001, 4'b0001, r_inst(1, 2, 9, 0, 6'h25), 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0));
    tbl.push_back(v("xor",   OP_XOR,  3'b001, 4'b0001, r_inst(1, 2, 9, 0, 6'h26), 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00));
    tbl.push_back(v("sll",   OP_SLL,  3'b100, 4'b0001, r_inst(0, 2, 9, 4, 6'h00), 32'hFFFF_FFFF, 32'h8000_0001, 32'h0000_0010));
    tbl.push_back(v("srl",   OP_SRL,  3'b100, 4'b0001, r_inst(0, 2, 9, 4, 6'h02), 32'hFFFF_FFFF, 32'h8000_0010, 32'h0800_0001));
    tbl.push_back(v("sra",   OP_SRA,  3'b100, 4'b0001, r_inst(0, 2, 9, 4, 6'h03), 32'hFFFF_FFFF, 32'h8000_0010, 32'hF800_0001));
    tbl.push_back(v("sllv",  OP_SLL,  3'b001, 4'b0001, r_inst(1, 2, 9, 0, 6'h04), 32'h0000_0021, 32'd1, 32'd2));
    tbl.push_back(v("lui",   OP_LUI,  3'b001, 4'b1000, i_inst(6'h0F, 0, 9, 16'h1234), 32'hFFFF_FFFF, 32'd0, 32'h1234_0000));
    tbl.push_back(v("addiu", OP_ADD,  3'b001, 4'b0010, i_inst(6'h09, 1, 9, 16'hFFFC), 32'h100, 32'd0, 32'h0000_00FC));
    tbl.push_back(v("pc+8",  OP_ADD,  3'b010, 4'b0100, i_inst(6'h03, 0, 9, 16'h0000), 32'd0, 32'd0, 32'hBFC0_0008));
    tbl.push_back(v("mfhi",  12'd0,   3'b000, 4'b0000, r_inst(0, 0, 9, 0, 6'h10), 32'd1, 32'd2, HI0));
    tbl.push_back(v("mflo",  12'd0,   3'b000, 4'b0000, r_inst(0, 0, 9, 0, 6'h12), 32'd1, 32'd2, LO0));

    // Reset with a live instruction on the input bus
    rst = 1'b1;
    stall_drv = 6'd0;
    id_to_ex_bus = mk(r_inst(1, 2, 9, 0, 6'h21), OP_ADD, 3'b001, 4'b0001, 1'b1, 4'hF, 1'b1, 5'd9, 1'b0, 32'd5, 32'd7);
    repeat (2) @(posedge clk);
    #1;
    chk("rst mem bus", 80'(ex_to_mem_bus), 80'd0);
    chk("rst id bus", 80'(ex_to_id_bus), 80'd0);
    chk("rst hilo", 80'(ex_hilo), 80'd0);
    chk("rst ctrl", 80'({stallreq_for_div, data_sram_en, inst_is_load}), 80'd0);
    rst = 1'b0;
    id_to_ex_bus = '0;

    foreach (tbl[i]) begin
      issue(mk(tbl[i].inst, tbl[i].op, tbl[i].s1, tbl[i].s2, 1'b0, 4'h0, 1'b1, 5'd9, 1'b0,
               tbl[i].r1, tbl[i].r2));
      chk({tbl[i].name, " ex_result"}, 80'(ex_to_mem_bus[31:0]), 80'(tbl[i].exp));
      chk({tbl[i].name, " to_id"}, 80'(ex_to_id_bus), 80'({1'b1, 5'd9, tbl[i].exp}));
    end

    // HI/LO writers
    issue(mk(r_inst(1, 2, 0, 0, 6'h18), 12'd0, 3'd0, 4'd0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'hFFFF_FFFD, 32'd5));
    chk("mult", 80'(ex_hilo), 80'({1'b1, 64'hFFFF_FFFF_FFFF_FFF1}));
    issue(mk(r_inst(1, 2, 0, 0, 6'h19), 12'd0, 3'd0, 4'd0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'hFFFF_FFFF, 32'd2));
    chk("multu", 80'(ex_hilo), 80'({1'b1, 32'h1, 32'hFFFF_FFFE}));
    issue(mk(r_inst(1, 0, 0, 0, 6'h11), 12'd0, 3'd0, 4'd0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'h1111_2222, 32'd0));
    chk("mthi", 80'(ex_hilo), 80'({1'b1, 32'h1111_2222, LO0}));
    issue(mk(r_inst(1, 0, 0, 0, 6'h13), 12'd0, 3'd0, 4'd0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'h3333_4444, 32'd0));
    chk("mtlo", 80'(ex_hilo), 80'({1'b1, HI0, 32'h3333_4444}));

    // Store and loads
    issue(mk(i_inst(6'h2B, 1, 2, 16'hFFFC), OP_ADD, 3'b001, 4'b0010, 1'b1, 4'hF, 1'b0, 5'd0, 1'b0, 32'h100, 32'hCAFE_BABE));
    chk("sw mem", 80'({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}),
        80'({1'b1, 4'hF, 32'h0000_00FC, 32'hCAFE_BABE}));
    chk("sw not load", 80'(inst_is_load), 80'd0);
    issue(mk(i_inst(6'h23, 1, 2, 16'hFFFC), OP_ADD, 3'b001, 4'b0010, 1'b1, 4'h0, 1'b1, 5'd2, 1'b1, 32'h100, 32'd0));
    chk("lw mem", 80'({inst_is_load, data_sram_en, data_sram_wen, data_sram_addr}),
        80'({1'b1, 1'b1, 4'h0, 32'h0000_00FC}));
    issue(mk(i_inst(6'h20, 1, 2, 16'h0004), OP_ADD, 3'b001, 4'b0010, 1'b1, 4'h0, 1'b1, 5'd2, 1'b1, 32'h100, 32'd0));
    chk("lb load", 80'(inst_is_load), 80'd1);
    issue(mk(i_inst(6'h24, 1, 2, 16'h0004), OP_ADD, 3'b001, 4'b0010, 1'b1, 4'h0, 1'b1, 5'd2, 1'b1, 32'h100, 32'd0));
    chk("lbu load", 80'({inst_is_load, data_sram_addr}), 80'({1'b1, 32'h104}));

    // Hold (ID and EX stopped), then bubble (ID stopped, EX running)
    id_to_ex_bus = mk(r_inst(1, 2, 9, 0, 6'h21), OP_ADD, 3'b001, 4'b0001, 1'b1, 4'h0, 1'b1, 5'd9, 1'b0, 32'd1, 32'd1);
    stall_drv = 6'b001111;
    @(posedge clk); #1;
    chk("hold", 80'({inst_is_load, data_sram_addr}), 80'({1'b1, 32'h104}));
    stall_drv = 6'b000111;
    @(posedge clk); #1;
    chk("bubble ctrl", 80'({ex_to_mem_bus[37], data_sram_en, ex_to_id_bus[37]}), 80'd0);
    chk("bubble bus", 80'(ex_to_mem_bus), 80'd0);
    stall_drv = 6'd0;
    id_to_ex_bus = '0;

    // Directed divides
    run_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    run_div("divu 10/0", 1'b0, 32'd10, 32'd0, 32'hFFFF_FFFF, 32'd10);
    run_div("div -5/0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB);

    // Reset during BUSY at count 10
    id_to_ex_bus = mk(r_inst(1, 2, 0, 0, 6'h1A), 12'd0, 3'd0, 4'd0, 1'b1, 4'hF, 1'b1, 5'd7, 1'b0,
                      32'hFFFF_FF9C, 32'd3);
    @(posedge clk); #1;
    repeat (11) @(posedge clk);
    #1;
    chk("mid-div busy", 80'(stallreq_for_div), 80'd1);
    rst = 1'b1;
    id_to_ex_bus = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid-div rst", 80'({stallreq_for_div, ex_hilo[64], data_sram_en, ex_to_mem_bus[37]}), 80'd0);
    m = div_model(1'b1, 32'hFFFF_FF9C, 32'd3);
    run_div("div after rst", 1'b1, 32'hFFFF_FF9C, 32'd3, m[31:0], m[63:32]);

    // Randomized ALU against the reference model
    for (int i = 0; i < 200; i++) begin
      k   = $urandom_range(0, 11);
      op  = 12'(12'h800 >> k);
      r1  = $urandom;
      r2  = $urandom;
      imm = 16'($urandom);
      sel = $urandom_range(0, 2);
      s2  = (sel == 0) ? 4'b0001 : ((sel == 1) ? 4'b0010 : 4'b1000);
      expv = alu_model(k, r1, (sel == 0) ? r2 : ((sel == 1) ? {{16{imm[15]}}, imm} : {16'd0, imm}));
      issue(mk(i_inst(6'h0F, 5'd0, 5'd3, imm), op, 3'b001, s2, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, r1, r2));
      chk($sformatf("rand alu k=%0d", k), 80'(ex_to_mem_bus[31:0]), 80'(expv));
    end

    // Randomized multiplies
    for (int i = 0; i < 20; i++) begin
      r1 = $urandom; r2 = $urandom; sgn = 1'($urandom);
      if (sgn) m = 64'(longint'($signed(r1)) * longint'($signed(r2)));
      else     m = {32'd0, r1} * {32'd0, r2};
      issue(mk(r_inst(1, 2, 0, 0, sgn ? 6'h18 : 6'h19), 12'd0, 3'd0, 4'd0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, r1, r2));
      chk($sformatf("rand mult s=%0d", sgn), 80'(ex_hilo), 80'({1'b1, m}));
    end

    // Randomized divides
    for (int i = 0; i < 12; i++) begin
      r1  = $urandom;
      r2  = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom);
      if (i % 4 == 1) r2 = r2 >> $urandom_range(0, 31);
      sgn = 1'($urandom);
      m   = div_model(sgn, r1, r2);
      run_div($sformatf("rand div s=%0d", sgn), sgn, r1, r2, m[31:0], m[63:32]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have ports: clk input 1, pipeline clock; rst input 1, reset, synchronous, active-high.
REQ-002 SHALL have stall input StallBus (6): per-stage Stop/NoStop vector; bit 2 is ID, bit 3 is EX.
REQ-003 SHALL have id_to_ex_bus input 223: {hi_data, lo_data, pc, inst, alu_op[11:0], sel_alu_src1[2:0], sel_alu_src2[3:0], data_ram_en, data_ram_wen[3:0], rf_we, rf_waddr[4:0], sel_rf_res, rdata1, rdata2}.
REQ-004 SHALL have ex_to_mem_bus output 76: {pc, data_ram_en, data_ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result}.
REQ-005 SHALL have ex_to_id_bus output 38: {rf_we[37], rf_waddr[36:32], ex_result[31:0]}.
REQ-006 SHALL have ex_hilo output 65: {hilo_we, hi_wdata, lo_wdata}.
REQ-007 SHALL have inst_is_load output 1: EX holds lw/lb/lbu.
REQ-008 SHALL have stallreq_for_div output 1: EX requests pipeline hold.
REQ-009 SHALL have data_sram_en output 1, data_sram_wen output 4, data_sram_addr output 32, data_sram_wdata output 32.

Function
REQ-010 Pipeline register SHALL load zero when stall[2]=Stop and stall[3]=NoStop, load id_to_ex_bus when stall[2]=NoStop, else hold.
REQ-011 src1 = rdata1 | pc | zero-extended sa; src2 = rdata2 | sign-extended imm | 32'd8 | zero-extended imm, one-hot per sel fields.
REQ-012 ALU SHALL implement add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui; shifts use src1[4:0]; results 32-bit, wrap-around, no overflow trap.
REQ-013 ex_result SHALL be hi_data for mfhi, lo_data for mflo, else the ALU result.
REQ-014 data_sram_en = data_ram_en, and addr = ALU result.
- sw: wen=4'b1111, wdata=rdata2.
- Loads: wen=4'b0000.
REQ-015 mult/multu SHALL be combinational 64-bit products; hilo_we=1 in the same cycle.
REQ-016 div/divu SHALL use a radix-2 restoring divider FSM: IDLE, BUSY, DONE.
- IDLE->BUSY on a div instruction in EX, with operands latched (magnitudes for signed div).
- BUSY: 32 iterations, 5-bit counter; at count 31 -> DONE.
- DONE: result valid for one cycle, then -> IDLE.
REQ-017 stallreq_for_div SHALL be 1 in the IDLE cycle where div is detected and in all BUSY cycles, and 0 in DONE; a div occupies EX for 34 cycles.
REQ-018 In DONE, hilo_we=1, with hi=remainder and lo=quotient.
- Signed div: quotient negated if operand signs differ; remainder takes the dividend's sign.
REQ-019 Divide by zero SHALL give lo=32'hFFFFFFFF and hi=dividend, with no exception, after full latency.
REQ-020 mthi SHALL write hi=rdata1 with lo=lo_data; mtlo SHALL write lo=rdata1 with hi=hi_data; hilo_we=1 in both cases.
REQ-021 While the divider is BUSY, register writes and memory outputs of the held instruction SHALL be suppressed (rf_we=0, data_sram_en=0) until DONE.

Reset
REQ-022 On rst, the pipeline register, divider FSM (IDLE), counter and operand latches SHALL clear in the same edge, including mid-division; the outputs then equal the decode of an all-zero bus: stallreq_for_div=0, hilo_we=0, data_sram_en=0, rf_we=0.

Structure
REQ-023 The defines header SHALL hold ID_TO_EX_WD=223, EX_TO_MEM_WD=76, EX_TO_ID_WD=38, StallBus, Stop/NoStop, and the div FSM state encodings.
REQ-024 The divider SHALL be sub-module div_iter (start, signed_en, a, b -> busy, done, quot, rem); everything else stays inline.

Verification
REQ-025 addu with rdata1=5, rdata2=7 -> ex_result=12 and ex_to_id_bus[36:32]=rd one cycle after the pipeline-register load.
REQ-026 div with -7 by 2 -> stallreq_for_div high for 33 cycles; in DONE, lo=-3, hi=-1, hilo_we=1.
REQ-027 divu with 10 by 0 -> after 34 cycles, lo=32'hFFFFFFFF and hi=10.
REQ-028 sw at base 0x100 with imm -4 -> data_sram_addr=0xFC, wen=1111, wdata=rdata2; lw sets inst_is_load=1 and wen=0000.
REQ-029 rst asserted at BUSY count 10 -> next cycle state IDLE, stallreq_for_div=0, hilo_we=0.
REQ-030 stall[2]=Stop with stall[3]=NoStop -> bubble: rf_we=0, data_sram_en=0.
